// File: rtl/mult6_seq_ctrl.sv
// Sequencing controller: 6x6 unsigned multiply built from one shared 3x3
// multiplier over four CALC cycles, with valid/ready on both sides.
module mult6_seq_ctrl #(
  parameter int OUT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       a,
  input  logic [5:0]       b,
  input  logic             clear,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] product,
  output logic             ov
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and payload is held while valid
  // waits for ready.

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [5:0]  a_r;
  logic [5:0]  b_r;
  logic [1:0]  step;
  logic [11:0] acc;

  logic [2:0]  ma;
  logic [2:0]  mb;
  logic [5:0]  pp6;
  logic [11:0] pp;

  // step[0] picks the high multiplicand digit, step[1] the high multiplier digit.
  always_comb begin
    ma  = step[0] ? a_r[5:3] : a_r[2:0];
    mb  = step[1] ? b_r[5:3] : b_r[2:0];
    pp6 = {3'b000, ma} * {3'b000, mb};
    pp  = 12'd0;
    case (step)
      2'd0:    pp = {6'd0, pp6};
      2'd1,
      2'd2:    pp = {3'd0, pp6, 3'd0};
      default: pp = {pp6, 6'd0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state     <= IDLE;
      a_r       <= 6'd0;
      b_r       <= 6'd0;
      step      <= 2'd0;
      acc       <= 12'd0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            acc      <= 12'd0;
            step     <= 2'd0;
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          acc  <= acc + pp;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign product = acc[OUT_W-1:0];

  generate
    if (OUT_W >= 12) begin : g_no_ov
      assign ov = 1'b0;
    end else begin : g_ov
      assign ov = |acc[11:OUT_W];
    end
  endgenerate

endmodule

// File: tb/tb_mult6_seq_ctrl.sv
// Directed bench for mult6_seq_ctrl: two instances (12-bit and 8-bit product)
// share stimulus; expected values are hand-computed or derived from a*b.
module tb_mult6_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready8;
  logic [5:0]  a;
  logic [5:0]  b;
  logic        clear;
  logic        busy;
  logic        busy8;
  logic        out_valid;
  logic        out_valid8;
  logic        out_ready;
  logic [11:0] product;
  logic [7:0]  product8;
  logic        ov;
  logic        ov8;

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  mult6_seq_ctrl #(.OUT_W(12)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .clear(clear), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .ov(ov)
  );

  mult6_seq_ctrl #(.OUT_W(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a), .b(b), .clear(clear), .busy(busy8), .out_valid(out_valid8),
    .out_ready(out_ready), .product(product8), .ov(ov8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Present an operand pair until accepted (bounded), then drop in_valid.
  task automatic issue(input logic [5:0] av, input logic [5:0] bv);
    int n;
    a = av;
    b = bv;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("issue_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("done_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    logic [11:0] exp_p;
    int          stall;

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 6'd0; b = 6'd0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_product", {20'd0, product}, 32'd0);
    chk("rst_ov", {31'd0, ov}, 32'd0);

    // 5*6 with exact latency
    out_ready = 1'b1;
    a = 6'd5; b = 6'd6; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_in_ready_drop", {31'd0, in_ready}, 32'd0);
    chk("lat_busy", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("lat_out_valid_low", {31'd0, out_valid}, 32'd0);
      tick();
    end
    chk("lat_out_valid_c5", {31'd0, out_valid}, 32'd1);
    chk("lat_product", {20'd0, product}, 32'd30);
    chk("lat_ov", {31'd0, ov}, 32'd0);
    tick();
    chk("lat_in_ready_back", {31'd0, in_ready}, 32'd1);
    chk("lat_out_valid_gone", {31'd0, out_valid}, 32'd0);

    // 63*63 on both widths
    issue(6'd63, 6'd63);
    wait_done();
    chk("max_product12", {20'd0, product}, 32'hF81);
    chk("max_ov12", {31'd0, ov}, 32'd0);
    chk("max_product8", {24'd0, product8}, 32'h81);
    chk("max_ov8", {31'd0, ov8}, 32'd1);
    tick();

    // Back-to-back with in_valid held: accepts exactly 6 cycles apart
    a = 6'd0; b = 6'd63; in_valid = 1'b1;
    tick();
    a = 6'd63; b = 6'd1;
    for (int i = 1; i <= 4; i++) begin
      chk("b2b_in_ready_low", {31'd0, in_ready}, 32'd0);
      tick();
    end
    chk("b2b_out_valid1", {31'd0, out_valid}, 32'd1);
    chk("b2b_in_ready_low_c5", {31'd0, in_ready}, 32'd0);
    chk("b2b_product1", {20'd0, product}, 32'd0);
    tick();
    chk("b2b_in_ready_c6", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b_accepted2", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 4; i++) tick();
    chk("b2b_out_valid2", {31'd0, out_valid}, 32'd1);
    chk("b2b_product2", {20'd0, product}, 32'd63);
    tick();

    // Consumer stall: 36*9 held for 3 cycles
    out_ready = 1'b0;
    issue(6'd36, 6'd9);
    wait_done();
    in_valid = 1'b1; a = 6'd1; b = 6'd1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_product", {20'd0, product}, 32'd324);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("stall_product_last", {20'd0, product}, 32'd324);
    out_ready = 1'b1;
    tick();
    chk("stall_xfer_done", {31'd0, out_valid}, 32'd0);
    chk("stall_in_ready_back", {31'd0, in_ready}, 32'd1);

    // Abort during CALC step2, first with reset, then with clear
    for (int k = 0; k < 2; k++) begin
      a = 6'd7; b = 6'd56; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      if (k == 0) reset = 1'b1; else clear = 1'b1;
      tick();
      reset = 1'b0; clear = 1'b0;
      chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_product", {20'd0, product}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        chk("abort_no_result", {31'd0, out_valid}, 32'd0);
        tick();
      end
    end

    // Full sweep with random consumer stalls
    out_ready = 1'b0;
    for (int ai = 0; ai < 64; ai++) begin
      for (int bi = 0; bi < 64; bi++) begin
        exp_q.push_back(12'(ai * bi));
        issue(6'(ai), 6'(bi));
        wait_done();
        stall = $urandom_range(0, 2);
        for (int s = 0; s < stall; s++) tick();
        exp_p = exp_q.pop_front();
        chk("sweep_product12", {20'd0, product}, {20'd0, exp_p});
        chk("sweep_ov12", {31'd0, ov}, 32'd0);
        chk("sweep_product8", {24'd0, product8}, {24'd0, exp_p[7:0]});
        chk("sweep_ov8", {31'd0, ov8}, {31'd0, (exp_p >= 12'd256)});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
